instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter A, default 16, program-counter and ROM-address width.
REQ-002 SHALL provide parameter IW, default 9, instruction width.
REQ-003 SHALL provide parameter HALT_INST, default 9'h1FF, opcode that ends execution.
REQ-004 SHALL provide parameter MAX_PC, default 1000, PC value at which fetch stops without issuing.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start  input  1  synchronous pulse, (re)launch fetch at start_addr.
REQ-009 SHALL have port start_addr  input  A  launch address.
REQ-010 SHALL have port stall  input  1  downstream not ready; holds the issued instruction.
REQ-011 SHALL have port branch_taken  input  1  redirect request from execute.
REQ-012 SHALL have port branch_target  input  A  absolute redirect address.
REQ-013 SHALL have port rom_addr  output  A  combinational ROM address, equal to pc.
REQ-014 SHALL have port rom_data  input  IW  ROM word for rom_addr, same cycle.
REQ-015 SHALL have port instr  output  IW  registered issued instruction.
REQ-016 SHALL have port instr_pc  output  A  address of instr.
REQ-017 SHALL have port instr_valid  output  1  instr holds a live instruction.
REQ-018 SHALL have port halt  output  1  high in IDLE and HALTED, low in RUN.
REQ-019 SHALL have port fetch_count  output  16  instructions issued since last start.

Function
REQ-020 SHALL implement states IDLE, RUN, HALTED; start from any state -> RUN next cycle.
REQ-021 On start: pc<=start_addr, instr_valid<=0, fetch_count<=0; start outranks all other inputs.
REQ-022 RUN, "advance" = !instr_valid || !stall; on advance with no branch: instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1, fetch_count+=1.
REQ-023 RUN, instr_valid && stall, no branch: pc, instr, instr_pc, instr_valid, fetch_count hold.
REQ-024 RUN, branch_taken: pc<=branch_target, instr_valid<=0 (one-cycle bubble), no issue; branch outranks stall.
REQ-025 pc+1 SHALL wrap from 2^A-1 to 0.
REQ-026 RUN, advance and rom_data==HALT_INST: issue it per REQ-022, pc holds, -> HALTED.
REQ-027 RUN, advance and pc==MAX_PC: no issue, instr_valid<=0, -> HALTED.
REQ-028 Simultaneous branch_taken and halt condition: branch wins, stay RUN.
REQ-029 HALTED: pc and fetch_count hold; instr_valid cleared on first cycle with stall=0; branch_taken ignored.
REQ-030 IDLE: no fetch; all outputs hold reset values; branch_taken and stall ignored.
REQ-031 fetch_count SHALL saturate at 16'hFFFF.
REQ-032 Latency: ROM word at rom_addr appears on instr one cycle after the advancing edge.

Reset
REQ-033 reset low SHALL immediately force IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, fetch_count=0, halt=1, regardless of clk.
REQ-034 Reset asserted mid-RUN SHALL discard in-flight instruction; after release block stays IDLE until start.

Verification
REQ-035 Reset, start with start_addr=0, ROM 0..3 = 9'h001..9'h004, no stall -> instr 001,002,003,004 on consecutive cycles, instr_pc 0..3, halt=0.
REQ-036 stall high 3 cycles while instr=9'h002 valid -> instr, instr_pc=1, pc=2 hold; resumes with 9'h003 after stall drops.
REQ-037 branch_taken, target=16'h0040, with stall high -> next cycle instr_valid=0, rom_addr=0x40; following cycle instr_pc=0x40.
REQ-038 ROM[5]=9'h1FF -> issued at instr_pc=5, halt=1 next cycle, fetch_count=6, instr_valid drops after stall=0; start_addr=0 start relaunches with fetch_count=0.
REQ-039 start_addr=998, no halt opcode -> issues 998, 999, then halt=1 at pc=1000 with no third issue; start_addr=16'hFFFF in RUN -> wraps to pc 0.
REQ-040 reset pulsed low between clk edges mid-RUN -> outputs at reset values immediately; start later -> fetch from start_addr.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks a same-cycle ROM from a launch address and issues
// one registered instruction per advance. Supports stall, branch redirect, and halt.
module instr_fetch #(
    parameter int             A         = 16,
    parameter int             IW        = 9,
    parameter logic [IW-1:0]  HALT_INST = 9'h1FF,
    parameter int             MAX_PC    = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [A-1:0]  start_addr,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [A-1:0]  branch_target,
    output logic [A-1:0]  rom_addr,
    input  logic [IW-1:0] rom_data,
    output logic [IW-1:0] instr,
    output logic [A-1:0]  instr_pc,
    output logic          instr_valid,
    output logic          halt,
    output logic [15:0]   fetch_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t        state_q, state_d;
    logic [A-1:0]  pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [A-1:0]  ipc_q, ipc_d;
    logic          vld_q, vld_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          advance;

    assign advance = !vld_q || !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = RUN;
            pc_d    = start_addr;
            vld_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    // A redirect wins over stall and over either halt condition.
                    if (branch_taken) begin
                        pc_d  = branch_target;
                        vld_d = 1'b0;
                    end else if (advance) begin
                        if (pc_q == A'(MAX_PC)) begin
                            vld_d   = 1'b0;
                            state_d = HALTED;
                        end else begin
                            instr_d = rom_data;
                            ipc_d   = pc_q;
                            vld_d   = 1'b1;
                            cnt_d   = cnt_q + 16'(cnt_q != 16'hFFFF);
                            if (rom_data == HALT_INST) state_d = HALTED;
                            else                       pc_d    = pc_q + A'(1);
                        end
                    end
                end
                // The last issued instruction stays visible until downstream takes it.
                HALTED: if (!stall) vld_d = 1'b0;
                default: ;
            endcase
        end
    end

    assign rom_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = vld_q;
    assign fetch_count = cnt_q;
    assign halt        = (state_q != RUN);

endmodule
